spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master_if.sv | 40 ++++
 rtl/spi_master.sv | 188 ++++++++++++++++++
 tb/tb_spi_master.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// ---------------------------------------------------------------------------
// spi_master_if
//   Bundles the request/response handshake and the SPI pins of spi_master.
//
//   start    : request to begin a frame (pulse or level)
//   cmd      : frame type, 00 wr addr / 01 wr data / 10 rd addr / 11 rd data
//   tx_data  : payload shifted out after cmd
//   busy     : frame (including the trailing gap) in progress
//   done     : one-cycle pulse at frame end
//   rx_data  : last byte received by a read-data frame
//   rx_valid : one-cycle pulse with done for read-data frames
//   SS_n     : slave select, active low
//   MOSI     : serial data to slave
//   MISO     : serial data from slave, synchronous to clk
//
//   master modport : the spi_master view
//   slave  modport : the view of whatever drives requests and the MISO pin
// ---------------------------------------------------------------------------
interface spi_master_if;
    logic       start;
    logic [1:0] cmd;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;

    modport master (
        input  start, cmd, tx_data, MISO,
        output busy, done, rx_data, rx_valid, SS_n, MOSI
    );

    modport slave (
        output start, cmd, tx_data, MISO,
        input  busy, done, rx_data, rx_valid, SS_n, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// ---------------------------------------------------------------------------
// spi_master
//   Single-clock SPI-style frame master. A frame is one SELECT cycle
//   (SS_n low, MOSI 0), ten MOSI bits {cmd, tx_data} MSB first, and for
//   read-data frames (cmd 11) an optional turnaround followed by eight MISO
//   samples. Every frame is followed by GAP cycles with SS_n high.
//
//   Parameters
//     TURNAROUND : idle cycles between last MOSI bit and first MISO sample (0..7)
//     GAP        : cycles SS_n stays high after a frame before IDLE (1..15)
//
//   Ports
//     clk   : system clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : spi_master_if.master (handshake + SPI pins)
// ---------------------------------------------------------------------------
module spi_master #(
    parameter int TURNAROUND = 1,
    parameter int GAP        = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    spi_master_if.master    bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SHIFT,
        S_WAIT,
        S_READ,
        S_GAP
    } state_t;

    // One shared counter is enough: the phases never overlap and the
    // longest count (GAP-1 = 14) fits in four bits.
    localparam logic [3:0] L_SHIFT_LAST = 4'd9;
    localparam logic [3:0] L_READ_LAST  = 4'd7;
    localparam logic [3:0] L_WAIT_LAST  = 4'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam logic [3:0] L_GAP_LAST   = 4'(GAP - 1);

    state_t     r_state,    w_state_next;
    logic [9:0] r_frame,    w_frame_next;
    logic       r_is_read,  w_is_read_next;
    logic [3:0] r_cnt,      w_cnt_next;
    logic [7:0] r_shift,    w_shift_next;
    logic [7:0] r_rx_data,  w_rx_data_next;
    logic       r_ss_n,     w_ss_n_next;
    logic       r_mosi,     w_mosi_next;
    logic       r_busy,     w_busy_next;
    logic       r_done,     w_done_next;
    logic       r_rx_valid, w_rx_valid_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_frame    <= '0;
            r_is_read  <= 1'b0;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_rx_data  <= 8'h00;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_frame    <= w_frame_next;
            r_is_read  <= w_is_read_next;
            r_cnt      <= w_cnt_next;
            r_shift    <= w_shift_next;
            r_rx_data  <= w_rx_data_next;
            r_ss_n     <= w_ss_n_next;
            r_mosi     <= w_mosi_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_rx_valid <= w_rx_valid_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_frame_next    = r_frame;
        w_is_read_next  = r_is_read;
        w_cnt_next      = r_cnt;
        w_shift_next    = r_shift;
        w_rx_data_next  = r_rx_data;
        w_ss_n_next     = r_ss_n;
        w_mosi_next     = 1'b0;
        w_busy_next     = r_busy;
        w_done_next     = 1'b0;
        w_rx_valid_next = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_frame_next   = {bus.cmd, bus.tx_data};
                    w_is_read_next = (bus.cmd == 2'b11);
                    w_busy_next    = 1'b1;
                    w_ss_n_next    = 1'b0;
                    w_cnt_next     = '0;
                    w_state_next   = S_SELECT;
                end
            end

            // The frame register is consumed from its top bit, so MOSI is
            // always frame[9] and the register shifts left each bit.
            S_SELECT: begin
                w_mosi_next  = r_frame[9];
                w_frame_next = {r_frame[8:0], 1'b0};
                w_cnt_next   = '0;
                w_state_next = S_SHIFT;
            end

            // Bit 9 went out on entry; counts 0..8 send bits 8..0 and count 9
            // is the edge that closes the last bit's cycle.
            S_SHIFT: begin
                if (r_cnt == L_SHIFT_LAST) begin
                    w_cnt_next = '0;
                    if (!r_is_read) begin
                        w_ss_n_next  = 1'b1;
                        w_done_next  = 1'b1;
                        w_state_next = S_GAP;
                    end else if (TURNAROUND == 0) begin
                        w_state_next = S_READ;
                    end else begin
                        w_state_next = S_WAIT;
                    end
                end else begin
                    w_mosi_next  = r_frame[9];
                    w_frame_next = {r_frame[8:0], 1'b0};
                    w_cnt_next   = r_cnt + 4'd1;
                end
            end

            S_WAIT: begin
                if (r_cnt == L_WAIT_LAST) begin
                    w_cnt_next   = '0;
                    w_state_next = S_READ;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end

            // The eighth sample is taken on the same edge that publishes the
            // byte, so rx_data is built from the shift register plus MISO.
            S_READ: begin
                w_shift_next = {r_shift[6:0], bus.MISO};
                if (r_cnt == L_READ_LAST) begin
                    w_rx_data_next  = {r_shift[6:0], bus.MISO};
                    w_rx_valid_next = 1'b1;
                    w_done_next     = 1'b1;
                    w_ss_n_next     = 1'b1;
                    w_cnt_next      = '0;
                    w_state_next    = S_GAP;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end

            S_GAP: begin
                if (r_cnt == L_GAP_LAST) begin
                    w_busy_next  = 1'b0;
                    w_cnt_next   = '0;
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_ss_n_next  = 1'b1;
                w_busy_next  = 1'b0;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign bus.SS_n     = r_ss_n;
    assign bus.MOSI     = r_mosi;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_master.sv
// ---------------------------------------------------------------------------
// tb_spi_master
//   Directed bench for spi_master. Expected frames are queued when a request
//   is driven and checked when the DUT pulses done. A per-cycle monitor
//   measures SS_n low/high lengths, captures MOSI and plays the slave on MISO.
// ---------------------------------------------------------------------------
module tb_spi_master;

    localparam int TA = 1;
    localparam int GP = 1;
    // Low-count value (cycles since SS_n fell, 1-based) of the first READ cycle.
    localparam int RD_FIRST = 12 + TA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    spi_master_if bus ();

    spi_master #(.TURNAROUND(TA), .GAP(GP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] frame;
        logic       is_read;
        logic [7:0] rx;
        int         len;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_starts = 0;
    int         low_cnt = 0;
    int         high_cnt = 0;
    int         last_high = 0;
    logic       prev_ss = 1'b1;
    logic [10:0] mosi_cap = '0;
    logic [7:0] slave_byte = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] c, input logic [7:0] d, input logic [7:0] rx);
        exp_t e;
        e.frame   = {c, d};
        e.is_read = (c == 2'b11);
        e.rx      = rx;
        e.len     = (c == 2'b11) ? 19 + TA : 11;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        if (!rst_n) begin
            prev_ss  = 1'b1;
            low_cnt  = 0;
            high_cnt = 0;
            return;
        end
        if (bus.SS_n == 1'b0) begin
            if (prev_ss) begin
                n_starts++;
                last_high = high_cnt;
                low_cnt   = 0;
                mosi_cap  = '0;
            end
            low_cnt++;
            if (low_cnt <= 11)
                mosi_cap = {mosi_cap[9:0], bus.MOSI};
            else
                check("mosi_low_after_shift", 32'(bus.MOSI), 0);
        end else begin
            high_cnt = prev_ss ? high_cnt + 1 : 1;
        end
        prev_ss = bus.SS_n;

        if (bus.done) begin
            check("sb_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ss_low_len", 32'(low_cnt), 32'(e.len));
                check("mosi_seq", 32'(mosi_cap), 32'({1'b0, e.frame}));
                check("rx_valid_at_done", 32'(bus.rx_valid), 32'(e.is_read));
                if (e.is_read)
                    check("rx_data", 32'(bus.rx_data), 32'(e.rx));
            end
        end else if (bus.rx_valid) begin
            check("rx_valid_without_done", 32'(bus.rx_valid), 0);
        end
    endtask

    // Advance one clock; sample 1 ns after the edge, then drive MISO.
    task automatic step();
        @(posedge clk);
        #1;
        monitor();
        if (rst_n && bus.SS_n == 1'b0 && low_cnt >= RD_FIRST && low_cnt < RD_FIRST + 8)
            bus.MISO = slave_byte[7 - (low_cnt - RD_FIRST)];
        else
            bus.MISO = 1'($urandom);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && bus.busy; i++) step();
        check("idle_timeout", 32'(bus.busy), 0);
    endtask

    task automatic check_rst_state(input string tag);
        check({tag, "_ss_n"},     32'(bus.SS_n), 1);
        check({tag, "_mosi"},     32'(bus.MOSI), 0);
        check({tag, "_busy"},     32'(bus.busy), 0);
        check({tag, "_done"},     32'(bus.done), 0);
        check({tag, "_rx_valid"}, 32'(bus.rx_valid), 0);
        check({tag, "_rx_data"},  32'(bus.rx_data), 0);
    endtask

    initial begin
        int s0;
        bus.start   = 1'b0;
        bus.cmd     = 2'b00;
        bus.tx_data = 8'h00;
        bus.MISO    = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 10; i++) begin
            bus.start   = 1'($urandom);
            bus.cmd     = 2'($urandom);
            bus.tx_data = 8'($urandom);
            step();
            check_rst_state("reset");
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;

        // Write address 0xFF, accepted on the first edge after release.
        bus.start = 1'b1; bus.cmd = 2'b00; bus.tx_data = 8'hFF;
        push_exp(2'b00, 8'hFF, 8'h00);
        step();
        bus.start = 1'b0;
        check("accept_busy", 32'(bus.busy), 1);
        check("accept_ss_n", 32'(bus.SS_n), 0);
        check("select_mosi", 32'(bus.MOSI), 0);
        wait_idle();

        // Read data, slave returns 0xA5; rx_data must hold afterwards.
        slave_byte = 8'hA5;
        bus.start = 1'b1; bus.cmd = 2'b11; bus.tx_data = 8'h3E;
        push_exp(2'b11, 8'h3E, 8'hA5);
        step();
        bus.start = 1'b0;
        wait_idle();
        for (int i = 0; i < 3; i++) step();
        check("rx_data_hold", 32'(bus.rx_data), 32'h A5);

        // Back-to-back with start held: cmd 01 then cmd 10.
        s0 = n_starts;
        bus.start = 1'b1; bus.cmd = 2'b01; bus.tx_data = 8'h3C;
        push_exp(2'b01, 8'h3C, 8'h00);
        step();
        bus.cmd = 2'b10; bus.tx_data = 8'hC3;
        push_exp(2'b10, 8'hC3, 8'h00);
        for (int i = 0; i < 60 && n_starts < s0 + 2; i++) step();
        bus.start = 1'b0;
        check("b2b_second_start", 32'(n_starts), 32'(s0 + 2));
        check("b2b_ss_high_len", 32'(last_high), 32'(GP + 1));
        wait_idle();

        // Mid-frame start pulse and input changes are ignored.
        s0 = n_starts;
        bus.start = 1'b1; bus.cmd = 2'b10; bus.tx_data = 8'h5A;
        push_exp(2'b10, 8'h5A, 8'h00);
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        bus.cmd = 2'b01; bus.tx_data = 8'h00; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.cmd = 2'b11; bus.tx_data = 8'hFF;
        wait_idle();
        for (int i = 0; i < GP + 4; i++) step();
        check("no_extra_frame", 32'(n_starts), 32'(s0 + 1));
        check("no_extra_busy", 32'(bus.busy), 0);

        // Reset on the 5th READ bit of a read-data frame.
        slave_byte = 8'h3C;
        bus.start = 1'b1; bus.cmd = 2'b11; bus.tx_data = 8'h81;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 40 && !(bus.SS_n == 1'b0 && low_cnt == RD_FIRST + 4); i++) step();
        check("reach_read_bit5", 32'(low_cnt), 32'(RD_FIRST + 4));
        rst_n = 1'b0;
        #1;
        check_rst_state("async_rst");
        for (int i = 0; i < 2; i++) begin
            step();
            check_rst_state("rst_hold");
        end
        rst_n = 1'b1;

        // Normal read frame after reset release.
        slave_byte = 8'h96;
        bus.start = 1'b1; bus.cmd = 2'b11; bus.tx_data = 8'h00;
        push_exp(2'b11, 8'h00, 8'h96);
        step();
        bus.start = 1'b0;
        check("post_rst_accept", 32'(bus.SS_n), 0);
        wait_idle();
        for (int i = 0; i < 3; i++) step();

        check("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
